matrix_multiply_dot_ctrl: RTL
=============================

# matrix_multiply_dot_ctrl

Sequencer that computes C = A × B for square N×N signed 32-bit matrices by time-sharing one external combinational 32×32 signed multiplier. It issues row/column reads to the A and B single-port memories, feeds the multiplier, accumulates each dot product, and writes each result to C. It uses an ap_start/ap_done block-level handshake and sits between the top-level control FSM and the matrix_multiply multiplier instance.

## Interface
- N, 4, matrix dimension (≥1)
- DATA_W, 32, element, product and accumulator width
- ADDR_W, 4, memory address width; must satisfy 2^ADDR_W ≥ N*N

- ap_clk  in  1  clock, rising edge
- ap_rst  in  1  reset, asynchronous, active-high
- ap_start  in  1  start request, sampled only in IDLE
- ap_done  out  1  one-cycle pulse: all N*N results written
- ap_idle  out  1  high in IDLE
- ap_ready  out  1  one-cycle pulse, coincident with ap_done
- a_address0 / b_address0  out  ADDR_W  read addresses for A and B
- a_ce0 / b_ce0  out  1  read enables; data valid 1 cycle later
- a_q0 / b_q0  in  DATA_W  read data
- c_address0  out  ADDR_W  write address for C
- c_ce0 / c_we0  out  1  write strobe pair, both high for a write
- c_d0  out  DATA_W  write data
- mul_din0 / mul_din1  out  DATA_W  multiplier operands
- mul_dout  in  DATA_W  multiplier product, combinational, low 32 bits, signed

## Operation
- States: IDLE, RUN, DRAIN, WRITE, DONE.
- IDLE: ap_idle=1. When ap_start=1: clear i, j and k, then go to RUN.
- RUN: assert a_ce0/b_ce0 with a_address0=i*N+k and b_address0=k*N+j. Increment k. After the read with k=N-1, go to DRAIN.
- A valid flag is the read enable delayed one cycle. When it is high, mul_din0=a_q0 and mul_din1=b_q0; otherwise both are 0.
- Accumulation on a valid cycle: the first product of an element loads acc=mul_dout; later products set acc=acc+mul_dout.
- Accumulator arithmetic is two's-complement DATA_W, wrapping unless the saturation feature is enabled (see Configuration).
- DRAIN: accumulate the last product, with no reads. Then go to WRITE.
- WRITE: c_ce0=c_we0=1, c_address0=i*N+j, c_d0=acc. Element order is row-major: increment j, and on wrap to 0 increment i.
  - If i=N-1 and j=N-1, go to DONE.
  - Otherwise clear k and go to RUN.
- DONE: ap_done=ap_ready=1 for one cycle, then go to IDLE.
- ap_start is ignored outside IDLE. If ap_start is held high through DONE, the next run begins on the cycle after returning to IDLE.
- Reset values: every output is 0 except ap_idle=1. Internal state: state=IDLE; i, j, k, acc and the valid flag are 0.
- Reset mid-run: asynchronous return to IDLE. An in-flight element is discarded with no C write, and there is no ap_done pulse.

## Timing
- Cycle 0: ap_start seen in IDLE.
- Per element e (0-based): base = 1 + e*(N+2).
  - RUN occupies cycles base to base+N-1.
  - DRAIN at base+N.
  - WRITE at base+N+1.
- ap_done occurs at cycle N*N*(N+2)+1; IDLE follows on the next cycle.
- Read latency is fixed at 1 cycle; the memories have no backpressure.
- The multiplier path is combinational, from a_q0/b_q0 through mul_dout into the acc register.

## Configuration
- MATRIX_MULTIPLY_DOT_SAT_EN defined: acc saturates on signed overflow to 0x7FFFFFFF (positive) or 0x80000000 (negative). A saturated value persists only until the next load.
- Not defined: acc wraps modulo 2^32.
- Multiplier products are truncated to DATA_W bits in both modes.

## Test plan
- N=2, A=identity, B={1,2,3,4} -> C writes at addresses 0,1,2,3 with data 1,2,3,4, at write cycles 4,8,12,16; ap_done at cycle 17.
- N=2, A={-1,2,3,-4}, B={5,-6,7,8} -> C={9,22,-13,-50}; ap_idle=0 from cycle 1 until DONE.
- N=2, A all 0x40000000, B all 2 -> each product is 0x80000000 and the two-term sum wraps to 0 with the macro off. With the macro on, the result is 0x80000000.
- Assert ap_rst at cycle 6 of an N=2 run -> all outputs are 0 the same cycle and ap_idle=1; no further C writes; a later ap_start produces a full correct run.
- Hold ap_start high continuously, N=2 -> ap_done at cycle 17, IDLE at 18, the second run's first read at cycle 19; ap_start pulses during RUN are ignored.
- N=1, A={-3}, B={7} -> one write of -21 to address 0 at cycle 3; ap_done at cycle 4.

Source files
------------

// File: rtl/matrix_multiply_dot_ctrl.sv
// C = A x B sequencer over one shared combinational multiplier; N+2 cycles per element, no backpressure.
// Optional signed saturation of the accumulator when MATRIX_MULTIPLY_DOT_SAT_EN is defined.
module matrix_multiply_dot_ctrl #(
  parameter int N      = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  output logic [ADDR_W-1:0] a_address0,
  output logic              a_ce0,
  input  logic [DATA_W-1:0] a_q0,
  output logic [ADDR_W-1:0] b_address0,
  output logic              b_ce0,
  input  logic [DATA_W-1:0] b_q0,
  output logic [ADDR_W-1:0] c_address0,
  output logic              c_ce0,
  output logic              c_we0,
  output logic [DATA_W-1:0] c_d0,
  output logic [DATA_W-1:0] mul_din0,
  output logic [DATA_W-1:0] mul_din1,
  input  logic [DATA_W-1:0] mul_dout
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, WRITE, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     i, j, k;
  logic [CW-1:0]     ni, nj;
  logic [DATA_W-1:0] acc, acc_nxt, sum;
  logic              vld, first;

  function automatic logic [ADDR_W-1:0] idx(input logic [CW-1:0] r, input logic [CW-1:0] c);
    return ADDR_W'(r) * ADDR_W'(N) + ADDR_W'(c);
  endfunction

  // Operands are forced to zero outside a read-data cycle so the multiplier input stays quiet.
  assign mul_din0 = vld ? a_q0 : '0;
  assign mul_din1 = vld ? b_q0 : '0;
  assign sum      = acc + mul_dout;

  always_comb begin
    acc_nxt = acc;
    if (vld) begin
      if (first) begin
        acc_nxt = mul_dout;
      end else begin
`ifdef MATRIX_MULTIPLY_DOT_SAT_EN
        if ((acc[DATA_W-1] == mul_dout[DATA_W-1]) && (sum[DATA_W-1] != acc[DATA_W-1]))
          acc_nxt = acc[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        else
          acc_nxt = sum;
`else
        acc_nxt = sum;
`endif
      end
    end
  end

  always_comb begin
    nj = j + CW'(1);
    ni = i;
    if (j == LAST) begin
      nj = '0;
      ni = i + CW'(1);
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state      <= IDLE;
      i          <= '0;
      j          <= '0;
      k          <= '0;
      acc        <= '0;
      vld        <= 1'b0;
      first      <= 1'b0;
      ap_done    <= 1'b0;
      ap_idle    <= 1'b1;
      ap_ready   <= 1'b0;
      a_address0 <= '0;
      a_ce0      <= 1'b0;
      b_address0 <= '0;
      b_ce0      <= 1'b0;
      c_address0 <= '0;
      c_ce0      <= 1'b0;
      c_we0      <= 1'b0;
      c_d0       <= '0;
    end else begin
      // k still names the read on the bus, so it also marks the first product of an element.
      vld      <= a_ce0;
      first    <= a_ce0 && (k == '0);
      acc      <= acc_nxt;
      ap_done  <= 1'b0;
      ap_ready <= 1'b0;
      c_ce0    <= 1'b0;
      c_we0    <= 1'b0;
      case (state)
        IDLE: begin
          if (ap_start) begin
            state      <= RUN;
            ap_idle    <= 1'b0;
            i          <= '0;
            j          <= '0;
            k          <= '0;
            a_ce0      <= 1'b1;
            b_ce0      <= 1'b1;
            a_address0 <= '0;
            b_address0 <= '0;
          end
        end
        RUN: begin
          k <= k + CW'(1);
          if (k == LAST) begin
            state <= DRAIN;
            a_ce0 <= 1'b0;
            b_ce0 <= 1'b0;
          end else begin
            a_address0 <= idx(i, k + CW'(1));
            b_address0 <= idx(k + CW'(1), j);
          end
        end
        DRAIN: begin
          state      <= WRITE;
          c_ce0      <= 1'b1;
          c_we0      <= 1'b1;
          c_address0 <= idx(i, j);
          c_d0       <= acc_nxt;
        end
        WRITE: begin
          i <= ni;
          j <= nj;
          if ((i == LAST) && (j == LAST)) begin
            state    <= DONE;
            ap_done  <= 1'b1;
            ap_ready <= 1'b1;
          end else begin
            state      <= RUN;
            k          <= '0;
            a_ce0      <= 1'b1;
            b_ce0      <= 1'b1;
            a_address0 <= idx(ni, '0);
            b_address0 <= idx('0, nj);
          end
        end
        DONE: begin
          state   <= IDLE;
          ap_idle <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
